// File: rtl/rs_pkg.sv
// Shared constants, types and GF(2^8) helper for the RS(204,188) DVB-T encoder.
// The optional per-packet bypass is enabled with the RS_BYPASS_EN macro (see rs_encoder).
package rs_pkg;

    localparam logic [7:0] GF_POLY = 8'h1D;
    localparam int         K_BYTES = 188;
    localparam int         N_BYTES = 204;
    localparam int         NPAR    = 16;

    // Index j holds the coefficient of x^j of g(x) = prod_{i=0..15}(x - alpha^i); the x^16 term is 1.
    localparam logic [7:0] GEN_COEF [NPAR] = '{
        8'h3B, 8'h24, 8'h32, 8'h62, 8'hE5, 8'h29, 8'h41, 8'hA3,
        8'h08, 8'h1E, 8'hD1, 8'h44, 8'hBD, 8'h68, 8'h0D, 8'h3B
    };

    typedef enum logic [0:0] {
        DATA   = 1'b0,
        PARITY = 1'b1
    } state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            acc = b[i] ? (acc ^ x) : acc;
            x   = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf256_const_mult.sv
// Combinational multiply of a byte by a fixed GF(2^8) constant (poly 0x11D).
module gf256_const_mult
    import rs_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);

    assign dout_o = gf_mul(din_i, COEF);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(204,188,t=8) encoder: 188 data bytes pass through, then 16 LFSR parity bytes.
// Optional feature macro RS_BYPASS_EN adds a Bypass input that sends a packet through without parity.
module rs_encoder
    import rs_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Din,
    input  logic       Din_Valid,
    input  logic       Din_Sop,
`ifdef RS_BYPASS_EN
    input  logic       Bypass,
`endif
    output logic       Din_Ready,
    output logic [7:0] Dout,
    output logic       Dout_Valid,
    input  logic       Dout_Ready,
    output logic       Dout_Sop,
    output logic       Dout_Eop,
    output logic       Err_Resync
);

    localparam logic [7:0] LAST_DATA = 8'(K_BYTES - 1);
    localparam logic [7:0] LAST_PAR  = 8'(NPAR - 1);

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] par_q [NPAR];
    logic [7:0] par_d [NPAR];
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       resync_q, resync_d;
    logic       bypass_q, bypass_d;

    logic       out_free_s, din_ready_s, accept_s, resync_s, first_s, pkt_bypass_s;
    logic [7:0] fb_s;
    logic [7:0] lfsr_base_s [NPAR];
    logic [7:0] lfsr_next_s [NPAR];
    logic [7:0] prod_s      [NPAR];

    assign accept_s = Din_Valid && din_ready_s;
    assign resync_s = accept_s && Din_Sop && (count_q != 8'd0);
    assign first_s  = (count_q == 8'd0) || resync_s;

`ifdef RS_BYPASS_EN
    assign pkt_bypass_s = first_s ? Bypass : bypass_q;
`else
    assign pkt_bypass_s = 1'b0;
`endif

    // A resync restarts the division, so the old remainder is discarded before feedback.
    always_comb begin
        for (int j = 0; j < NPAR; j++) begin
            lfsr_base_s[j] = resync_s ? 8'h00 : par_q[j];
        end
        fb_s = Din ^ lfsr_base_s[NPAR-1];
    end

    for (genvar g = 0; g < NPAR; g++) begin : g_mul
        gf256_const_mult #(.COEF(GEN_COEF[g])) u_mul (
            .din_i  (fb_s),
            .dout_o (prod_s[g])
        );
    end

    // LFSR division step for one accepted message byte.
    always_comb begin
        lfsr_next_s[0] = prod_s[0];
        for (int j = 1; j < NPAR; j++) begin
            lfsr_next_s[j] = lfsr_base_s[j-1] ^ prod_s[j];
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= DATA;
            count_q      <= 8'd0;
            par_q        <= '{default: 8'h00};
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            resync_q     <= 1'b0;
            bypass_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            par_q        <= par_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            resync_q     <= resync_d;
            bypass_q     <= bypass_d;
        end
    end

    // Next-state logic: message pass-through in DATA, parity drain in PARITY.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        par_d        = par_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        resync_d     = 1'b0;
        bypass_d     = (accept_s && first_s) ? pkt_bypass_s : bypass_q;
        case (state_q)
            DATA: begin
                if (accept_s) begin
                    dout_d       = Din;
                    dout_valid_d = 1'b1;
                    sop_d        = first_s;
                    eop_d        = 1'b0;
                    resync_d     = resync_s;
                    for (int j = 0; j < NPAR; j++) begin
                        par_d[j] = pkt_bypass_s ? 8'h00 : lfsr_next_s[j];
                    end
                    if (resync_s) begin
                        count_d = 8'd1;
                    end else if (count_q == LAST_DATA) begin
                        count_d = 8'd0;
                        eop_d   = pkt_bypass_s;
                        state_d = pkt_bypass_s ? DATA : PARITY;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else if (Dout_Ready) begin
                    dout_valid_d = 1'b0;
                    sop_d        = 1'b0;
                    eop_d        = 1'b0;
                end else begin
                    dout_valid_d = dout_valid_q;
                end
            end
            PARITY: begin
                if (out_free_s) begin
                    dout_d       = par_q[NPAR-1];
                    dout_valid_d = 1'b1;
                    sop_d        = 1'b0;
                    par_d[0]     = 8'h00;
                    for (int j = 1; j < NPAR; j++) begin
                        par_d[j] = par_q[j-1];
                    end
                    if (count_q == LAST_PAR) begin
                        count_d = 8'd0;
                        eop_d   = 1'b1;
                        state_d = DATA;
                    end else begin
                        count_d = count_q + 8'd1;
                        eop_d   = 1'b0;
                    end
                end else begin
                    state_d = PARITY;
                end
            end
            default: begin
                state_d = DATA;
                count_d = 8'd0;
            end
        endcase
    end

    // Handshake outputs derived from state and output-slot availability.
    always_comb begin
        out_free_s = !dout_valid_q || Dout_Ready;
        if (state_q == DATA) begin
            din_ready_s = out_free_s;
        end else begin
            din_ready_s = 1'b0;
        end
    end

    assign Din_Ready  = din_ready_s;
    assign Dout       = dout_q;
    assign Dout_Valid = dout_valid_q;
    assign Dout_Sop   = sop_q;
    assign Dout_Eop   = eop_q;
    assign Err_Resync = resync_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Randomized self-checking bench for rs_encoder, using a polynomial-division reference model.
module tb_rs_encoder;

    localparam int K = 188;
    localparam int N = 204;

    typedef logic [7:0] msg_t [K];
    typedef logic [7:0] cw_t  [N];
    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Din = 8'h00;
    logic       Din_Valid = 1'b0;
    logic       Din_Sop = 1'b0;
    logic       Din_Ready;
    logic [7:0] Dout;
    logic       Dout_Valid;
    logic       Dout_Ready = 1'b1;
    logic       Dout_Sop;
    logic       Dout_Eop;
    logic       Err_Resync;

    int checks = 0;
    int errors = 0;

    int   gexp [512];
    int   glog [256];
    int   gen  [17];
    exp_t expq [$];
    exp_t e;
    msg_t msg;
    cw_t  cw;
    cw_t  out_buf;
    int   out_idx = 0;
    int   xfer_cnt = 0;
    int   resync_cnt = 0;
    bit   bp_en = 1'b0;
    bit   stall_prev = 1'b0;
    logic [7:0] prev_dout;
    logic       prev_sop, prev_eop;

    rs_encoder dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Din        (Din),
        .Din_Valid  (Din_Valid),
        .Din_Sop    (Din_Sop),
        .Din_Ready  (Din_Ready),
        .Dout       (Dout),
        .Dout_Valid (Dout_Valid),
        .Dout_Ready (Dout_Ready),
        .Dout_Sop   (Dout_Sop),
        .Dout_Eop   (Dout_Eop),
        .Err_Resync (Err_Resync)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    // OR of the 16 syndromes S_i = c(alpha^i), i = 0..15; zero for a valid codeword.
    function automatic int syn_or(input cw_t c);
        int acc = 0;
        for (int i = 0; i < 16; i++) begin
            int s = 0;
            for (int n = 0; n < N; n++) s = gmul(s, gexp[i]) ^ int'(c[n]);
            acc |= s;
        end
        return acc;
    endfunction

    // Systematic codeword: message followed by remainder of m(x)*x^16 / g(x), highest order first.
    function automatic cw_t encode(input msg_t m);
        int   r [N];
        cw_t  c;
        for (int i = 0; i < N; i++) r[i] = (i < K) ? int'(m[i]) : 0;
        for (int i = 0; i < K; i++) begin
            int q = r[i];
            if (q != 0) for (int j = 1; j <= 16; j++) r[i+j] ^= gmul(q, gen[16-j]);
        end
        for (int i = 0; i < N; i++) c[i] = (i < K) ? m[i] : 8'(r[i]);
        return c;
    endfunction

    task automatic push_expected(input cw_t c, input int nbytes);
        exp_t x;
        for (int i = 0; i < nbytes; i++) begin
            x.d = c[i];
            x.sop = (i == 0);
            x.eop = (i == N - 1);
            expq.push_back(x);
        end
    endtask

    // Caller must be at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input logic sop);
        int   waitc = 0;
        logic acc;
        Din = b;
        Din_Sop = sop;
        Din_Valid = 1'b1;
        forever begin
            @(negedge Clk);
            acc = Din_Ready;
            @(posedge Clk);
            #1;
            if (acc) break;
            waitc++;
            if (waitc > 1000) begin
                chk("din_ready_timeout", 0, 1);
                break;
            end
        end
        Din_Valid = 1'b0;
        Din_Sop = 1'b0;
    endtask

    task automatic send_msg(input msg_t m, input int nbytes, input logic sop_first);
        for (int i = 0; i < nbytes; i++) send_byte(m[i], (i == 0) ? sop_first : 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && expq.size() != 0; i++) @(posedge Clk);
        #1;
        chk("drain_queue_empty", expq.size(), 0);
    endtask

    task automatic random_msg();
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(255, 0));
    endtask

    // Downstream ready: always 1 or a 50% random pattern.
    always @(posedge Clk) begin
        #1;
        Dout_Ready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    // Output compare process: every transfer against the model queue, plus stall stability.
    always @(negedge Clk) begin
        if (Reset) begin
            stall_prev = 1'b0;
            out_idx = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", Dout_Valid, 1);
                chk("stall_dout_held", Dout, prev_dout);
                chk("stall_sop_held", Dout_Sop, prev_sop);
                chk("stall_eop_held", Dout_Eop, prev_eop);
            end
            if (Dout_Valid && Dout_Ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("dout", Dout, e.d);
                    chk("dout_sop", Dout_Sop, e.sop);
                    chk("dout_eop", Dout_Eop, e.eop);
                end
                xfer_cnt++;
                if (Dout_Sop) out_idx = 0;
                if (out_idx < N) out_buf[out_idx] = Dout;
                out_idx++;
                if (Dout_Eop) begin
                    chk("dut_codeword_length", out_idx, N);
                    if (out_idx == N) chk("dut_syndromes_zero", syn_or(out_buf), 0);
                end
            end
            if (Err_Resync) resync_cnt++;
            stall_prev = Dout_Valid && !Dout_Ready;
            prev_dout = Dout;
            prev_sop = Dout_Sop;
            prev_eop = Dout_Eop;
        end
    end

    initial begin
        int x;
        int lowcnt;
        int target;
        cw_t bad;

        // GF(256) log/antilog tables and generator polynomial, independent of the RTL.
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            gexp[i+255] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 285;
        end
        gexp[510] = gexp[0];
        gexp[511] = gexp[1];
        for (int k = 0; k < 17; k++) gen[k] = 0;
        gen[0] = 1;
        for (int i = 0; i < 16; i++) begin
            for (int k = 16; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], gexp[i]);
            gen[0] = gmul(gen[0], gexp[i]);
        end

        // Hand-computed pins for the model: alpha^8, alpha^25, sum and product of the roots.
        chk("model_alpha8", gexp[8], 8'h1D);
        chk("model_alpha25", gexp[25], 8'h03);
        chk("model_gen_x15", gen[15], 8'h3B);
        chk("model_gen_x0", gen[0], 8'h3B);
        chk("model_gen_monic", gen[16], 1);

        // Reset values.
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset_dout", Dout, 8'h00);
        chk("reset_dout_valid", Dout_Valid, 0);
        chk("reset_dout_sop", Dout_Sop, 0);
        chk("reset_dout_eop", Dout_Eop, 0);
        chk("reset_err_resync", Err_Resync, 0);
        chk("reset_din_ready", Din_Ready, 1);
        @(posedge Clk);
        #1;

        // All-zero packet: zero parity and exactly 16 input-blocked cycles.
        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        cw = encode(msg);
        chk("zero_model_syndromes", syn_or(cw), 0);
        push_expected(cw, N);
        send_msg(msg, K, 1'b1);
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Din_Ready) break;
            lowcnt++;
        end
        chk("din_ready_low_parity_slots", lowcnt, 16);
        @(posedge Clk);
        #1;
        drain();

        // Impulse in the last message byte: parity equals g(x) coefficients, high order first.
        msg[K-1] = 8'h01;
        cw = encode(msg);
        for (int k = 0; k < 16; k++) chk("impulse_model_parity", cw[K+k], gen[15-k]);
        push_expected(cw, N);
        send_msg(msg, K, 1'b1);
        drain();

        // Random packets without and with downstream backpressure.
        for (int p = 0; p < 80; p++) begin
            bp_en = (p >= 40);
            random_msg();
            cw = encode(msg);
            chk("rand_model_syndromes", syn_or(cw), 0);
            bad = cw;
            bad[$urandom_range(N-1, 0)] ^= 8'($urandom_range(255, 1));
            chk("rand_corrupt_syndromes_nonzero", int'(syn_or(bad) != 0), 1);
            push_expected(cw, N);
            send_msg(msg, K, 1'($urandom_range(3, 0) != 0));
        end
        drain();
        chk("no_spurious_resync", resync_cnt, 0);

        // Premature Sop at byte 100: truncated packet gets no parity, new codeword follows.
        random_msg();
        cw = encode(msg);
        push_expected(cw, 100);
        send_msg(msg, 100, 1'b1);
        random_msg();
        cw = encode(msg);
        push_expected(cw, N);
        send_msg(msg, K, 1'b1);
        drain();
        chk("resync_pulse_count", resync_cnt, 1);
        bp_en = 1'b0;
        @(posedge Clk);
        #1;

        // Reset while parity byte 5 is on the output.
        random_msg();
        cw = encode(msg);
        push_expected(cw, N);
        target = xfer_cnt + K + 5;
        send_msg(msg, K, 1'b1);
        for (int i = 0; i < 200 && xfer_cnt < target; i++) begin
            @(posedge Clk);
            #1;
        end
        chk("reset_point_reached", int'(xfer_cnt >= target), 1);
        Reset = 1'b1;
        expq.delete();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_reset_dout_valid", Dout_Valid, 0);
        chk("post_reset_din_ready", Din_Ready, 1);
        @(posedge Clk);
        #1;
        random_msg();
        cw = encode(msg);
        push_expected(cw, N);
        send_msg(msg, K, 1'b1);
        drain();
        repeat (4) @(posedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_encoder.md
Name: rs_encoder

Overview:
- Systematic RS(204,188,t=8) encoder for the DVB-T transmit chain: the shortened RS(255,239) code over GF(2^8).
- Passes 188 message bytes through unchanged, then appends 16 parity bytes computed by a 16-stage GF(256) LFSR.
- Output codewords are the exact input format expected by the receive-side syndrome calculator; a zero-error codeword yields all-zero S_1..S_16.
- Sits between the MPEG-TS packetiser and the outer interleaver.

Parameters:
- K, 188, message bytes per codeword.
- NPAR, 16, parity bytes per codeword (fixed 2t; the generator coefficients are sized for 16).
- FCR, 0, first consecutive root: g(x)=prod_{i=0..15}(x-alpha^(FCR+i)); must match the syndrome calculator's root set.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Din  in  8  message byte.
- Din_Valid  in  1  Din valid.
- Din_Sop  in  1  Din is first byte of a packet.
- Din_Ready  out  1  byte accepted when Din_Valid&&Din_Ready.
- Dout  out  8  codeword byte (registered).
- Dout_Valid  out  1  Dout valid.
- Dout_Ready  in  1  downstream accepts when Dout_Valid&&Dout_Ready.
- Dout_Sop  out  1  first codeword byte.
- Dout_Eop  out  1  last (204th) codeword byte.
- Err_Resync  out  1  one-cycle pulse on premature Din_Sop.

Behaviour:
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02.
- Reset:
  - Dout=0; Dout_Valid, Dout_Sop, Dout_Eop, Err_Resync all 0.
  - LFSR registers R[0..15]=0; byte counter=0; state=DATA.
  - Din_Ready=1 from the first cycle after Reset deasserts.
  - Reset mid-codeword abandons it: no partial parity is emitted.
- Output slot free: out_free = !Dout_Valid || Dout_Ready.
- State DATA:
  - Din_Ready = out_free.
  - On accept: Dout<=Din, Dout_Valid<=1, Dout_Sop<=(count==0), Dout_Eop<=0.
  - LFSR update: fb=Din^R[15]; R[j]<=R[j-1]^(G[j]*fb) for j=1..15; R[0]<=G[0]*fb. Constant GF multiplies only.
  - count increments. On accept of byte K-1: count<=0, state<=PARITY.
- State PARITY:
  - Din_Ready=0.
  - Each cycle with out_free: Dout<=R[15], Dout_Valid<=1, then shift R[j]<=R[j-1], R[0]<=0.
  - Parity is emitted highest-order first.
  - On the 16th parity byte: Dout_Eop<=1, state<=DATA.
  - Registers are already zero after 16 shifts, so no clear cycle is needed; Din_Ready rises the following cycle.
- If neither accept nor parity issue occurs and Dout_Ready=1: Dout_Valid<=0, and Sop/Eop clear.
- Latency: input byte to Dout is 1 cycle. Throughput is 1 byte/cycle; each codeword takes 204 cycles without backpressure.
- Din_Sop handling:
  - Asserted at count==0: normal start.
  - Absent at count==0: the byte is still taken as the first byte.
  - Asserted at count!=0 in DATA: Err_Resync pulses. The LFSR restarts, with this byte as byte 0 (feedback computed from R=0), count<=1 and Dout_Sop<=1.
  - The truncated codeword is never given parity.
- Dout_Valid with Dout_Ready=0 holds Dout, Sop and Eop stable. Neither LFSR nor count advances.

Optional Feature:
- Macro RS_BYPASS_EN.
- When defined:
  - Adds input Bypass (1 bit), sampled on the accept of byte 0.
  - If Bypass=1, the packet passes through with the LFSR frozen at 0. PARITY is skipped and Dout_Eop is set on byte K-1, giving 188-byte output packets.
  - Bypass is ignored mid-packet.
- When undefined: no Bypass port; every packet gets parity.

Decomposition:
- Package rs_pkg:
  - GF_POLY=8'h1D.
  - Constants K_BYTES=188 and N_BYTES=204.
  - GEN_COEF[0..15] for FCR=0, precomputed.
  - State enum {DATA, PARITY}.
- Sub-module gf256_const_mult (byte in, constant parameter, byte out, combinational), instantiated 16 times.

Test Plan:
- All-zero 188-byte packet -> 188 zeros then 16 zero parity bytes; Dout_Sop on byte 0, Dout_Eop on byte 203.
- Bytes 0..186 = 0x00, byte 187 = 0x01 -> parity bytes equal GEN_COEF[15], GEN_COEF[14], ..., GEN_COEF[0].
- Random packets (≥1000) encoded -> fed to the syndrome calculator -> all 16 syndromes 0x00. Single-byte corruption gives nonzero syndromes.
- Dout_Ready random 50% duty cycle -> stream identical to the Dout_Ready=1 run; Dout stable while stalled; Din_Ready=0 for exactly the 16 parity slots.
- Din_Sop at byte 100 -> Err_Resync one pulse; new codeword starts; no parity emitted for the truncated packet.
- Reset asserted at parity byte 5 -> next cycle Dout_Valid=0 and Din_Ready=1; next packet's parity matches its golden value.
